// File: rtl/plot_pkg.sv
// Shared definitions for the plot receiver: state encoding, field widths,
// the plot-request record and the {y,x} framebuffer address packing rule.
package plot_pkg;

    localparam int COORD_W  = 7;
    localparam int COLOUR_W = 3;
    localparam int ADDR_W   = 2 * COORD_W;
    localparam int ENTRY_W  = 2 * COORD_W + COLOUR_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DRAIN = 2'd1,
        S_CLEAR = 2'd2
    } state_e;

    typedef struct packed {
        logic [COORD_W-1:0]  x;
        logic [COORD_W-1:0]  y;
        logic [COLOUR_W-1:0] c;
    } plot_t;

    // Framebuffer address: row in the upper half, column in the lower half.
    function automatic logic [ADDR_W-1:0] pack_addr(input logic [COORD_W-1:0] x,
                                                   input logic [COORD_W-1:0] y);
        return {y, x};
    endfunction

endpackage

// File: rtl/plot_fifo.sv
// Single-clock synchronous FIFO holding pending plot requests.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module plot_fifo
    import plot_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = ENTRY_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    // Status flags, guarded push/pop and pointer advance.
    always_comb begin
        empty    = (wr_ptr_q == rd_ptr_q);
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = do_push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = do_pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
    end

    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];

    // Pointer registers; reset empties the buffer.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array; contents need no reset because the pointers gate reads.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/plot_receiver.sv
// Plot receiver: buffers pixel plot requests and streams them to a
// framebuffer write port, with a drain-then-clear screen sequence.
// Optional build macro PLOT_RECEIVER_CLIP_EN discards off-screen plots.
//
// Handshake: a plot is accepted in any cycle where plot_in and ready are both
// high (and reset is low); ready depends only on registered state. A plot
// presented while ready is low is dropped and sets the sticky overflow flag.
module plot_receiver
    import plot_pkg::*;
#(
    parameter int         FIFO_DEPTH   = 8,
    parameter int         SCREEN_W     = 120,
    parameter int         SCREEN_H     = 120,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [COORD_W-1:0]  x_in,
    input  logic [COORD_W-1:0]  y_in,
    input  logic [COLOUR_W-1:0] c_in,
    input  logic                plot_in,
    input  logic                clear_screen,
    output logic                ready,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [COLOUR_W-1:0] mem_data,
    output logic                mem_we,
    output logic                busy,
    output logic                overflow,
    output logic [1:0]          state_dbg
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(SCREEN_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(SCREEN_H - 1);

    state_e              state_q, state_d;
    logic [COORD_W-1:0]  cx_q, cx_d;
    logic [COORD_W-1:0]  cy_q, cy_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [COLOUR_W-1:0] data_q, data_d;
    logic                we_q, we_d;
    logic                ovf_q, ovf_d;

    logic                fifo_full, fifo_empty;
    logic                push, pop, in_range;
    plot_t               wr_entry, rd_entry;

    // Acceptance, visibility filter and buffer handshake.
    always_comb begin
        ready = !fifo_full && (state_q == S_IDLE);
`ifdef PLOT_RECEIVER_CLIP_EN
        in_range = ({1'b0, x_in} < 8'(SCREEN_W)) && ({1'b0, y_in} < 8'(SCREEN_H));
`else
        in_range = 1'b1;
`endif
        push     = plot_in && ready && in_range && !reset;
        pop      = !fifo_empty && (state_q != S_CLEAR) && !reset;
        wr_entry = '{x: x_in, y: y_in, c: c_in};
    end

    plot_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (rd_entry),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Next-state: mode sequencing, clear raster scan and write-port update.
    always_comb begin
        state_d = state_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        if (plot_in && !ready) begin
            ovf_d = 1'b1;
        end
        case (state_q)
            S_IDLE: begin
                if (clear_screen) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (fifo_empty) begin
                    state_d = S_CLEAR;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            end
            S_CLEAR: begin
                we_d   = 1'b1;
                addr_d = pack_addr(cx_q, cy_q);
                data_d = CLEAR_COLOUR;
                if (cx_q == X_LAST && cy_q == Y_LAST) begin
                    state_d = S_IDLE;
                    cx_d    = '0;
                    cy_d    = '0;
                end else if (cx_q == X_LAST) begin
                    cx_d = '0;
                    cy_d = cy_q + 1'b1;
                end else begin
                    cx_d = cx_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (pop) begin
            we_d   = 1'b1;
            addr_d = pack_addr(rd_entry.x, rd_entry.y);
            data_d = rd_entry.c;
        end
    end

    // State and registered outputs; reset abandons any drain or clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cx_q    <= '0;
            cy_q    <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            we_q    <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            ovf_q   <= ovf_d;
        end
    end

    assign mem_addr  = addr_q;
    assign mem_data  = data_q;
    assign mem_we    = we_q;
    assign overflow  = ovf_q;
    assign busy      = !fifo_empty || (state_q != S_IDLE);
    assign state_dbg = state_q;

endmodule

// File: doc/plot_receiver.md
PLOT_RECEIVER -- requirements
Module: plot_receiver

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 8, plot-request buffer depth (power of two, >=2).
REQ-002 SHALL have parameter SCREEN_W, default 120, visible columns (1..128).
REQ-003 SHALL have parameter SCREEN_H, default 120, visible rows (1..128).
REQ-004 SHALL have parameter CLEAR_COLOUR, default 3'b000, colour written by screen clear.
REQ-005 SHALL have port clk  in  1  sole clock; all logic on posedge clk.
REQ-006 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-007 SHALL have ports x_in  in  7, y_in  in  7, c_in  in  3  pixel coordinate and colour.
REQ-008 SHALL have port plot_in  in  1  write strobe, one pixel per high cycle.
REQ-009 SHALL have port clear_screen  in  1  single-cycle clear request.
REQ-010 SHALL have port ready  out  1  high when a plot_in is accepted this cycle.
REQ-011 SHALL have ports mem_addr  out  14 ({y,x}), mem_data  out  3, mem_we  out  1  framebuffer write port.
REQ-012 SHALL have ports busy  out  1 (FIFO non-empty or clear active) and overflow  out  1 (sticky dropped-plot flag).

Function
REQ-013 SHALL push {x_in,y_in,c_in} into the FIFO when plot_in && ready.
REQ-014 SHALL drive ready = !full && state==S_IDLE, combinationally from registered state.
REQ-015 SHALL drop a plot_in arriving while ready is low and set overflow on the next edge.
REQ-016 SHALL pop one entry per cycle when non-empty in S_IDLE or S_DRAIN, registering it onto mem_addr/mem_data with mem_we high for exactly one cycle.
REQ-017 SHALL give push-to-mem_we latency of 1 cycle when the FIFO is empty, and preserve FIFO order.
REQ-018 SHALL support simultaneous push and pop in one cycle with count unchanged.
REQ-019 SHALL use states S_IDLE, S_DRAIN, S_CLEAR: S_IDLE--clear_screen-->S_DRAIN; S_DRAIN--empty-->S_CLEAR; S_CLEAR--last pixel written-->S_IDLE.
REQ-020 SHALL treat clear_screen in S_IDLE with FIFO empty as entering S_DRAIN, then S_CLEAR on the next cycle.
REQ-021 SHALL in S_CLEAR write CLEAR_COLOUR to every x<SCREEN_W, y<SCREEN_H, x fastest, from (0,0), one pixel per cycle, exactly SCREEN_W*SCREEN_H writes.
REQ-022 SHALL ignore clear_screen while in S_DRAIN or S_CLEAR.
REQ-023 SHALL wrap FIFO pointers modulo FIFO_DEPTH, with full and empty distinguished by an extra pointer bit.
REQ-024 SHALL hold mem_addr/mem_data at their last values while mem_we is low.

Reset
REQ-025 SHALL on reset set state S_IDLE, FIFO empty, clear counters 0, mem_we 0, mem_addr 0, mem_data 0, overflow 0, busy 0.
REQ-026 SHALL on reset mid-drain or mid-clear discard all pending entries and stop writing; mem_we SHALL be 0 the cycle after reset is sampled.
REQ-027 SHALL ignore plot_in and clear_screen in any cycle where reset is high.

Configuration
REQ-028 SHALL, with PLOT_RECEIVER_CLIP_EN defined, discard at push time any plot with x_in>=SCREEN_W or y_in>=SCREEN_H, without setting overflow; ready is unaffected.
REQ-029 SHALL, without PLOT_RECEIVER_CLIP_EN, write every accepted plot regardless of coordinates.

Structure
REQ-030 SHALL place the state encoding, colour width (3), coordinate width (7) and address-packing rule in shared package plot_pkg.
REQ-031 SHALL implement the buffer as sub-module plot_fifo (synchronous, single clock, width 17, depth FIFO_DEPTH), instantiated once.

Verification
REQ-032 Single plot x=5,y=9,c=3'b101 into empty FIFO -> next cycle mem_we=1, mem_addr=14'h0485, mem_data=3'b101.
REQ-033 Eight back-to-back plots held off by a pending clear -> ready low at the ninth plot, overflow=1, the eight accepted pixels written in order.
REQ-034 clear_screen with SCREEN_W=SCREEN_H=4 and 3 queued plots -> 3 plot writes, then 16 writes of CLEAR_COLOUR at addresses {0,0}..{3,3} x-fastest, ready low throughout, then S_IDLE.
REQ-035 Reset asserted at clear pixel 7 -> mem_we=0 the next cycle, busy=0, overflow=0, ready=1.
REQ-036 With PLOT_RECEIVER_CLIP_EN defined, plot x=120,y=0 (defaults) -> no mem_we and overflow stays 0; x=119,y=119 -> one write at 14'h3BF7.
